// File: rtl/down_counter_timer_ctrl_if.sv
// down_counter_timer_ctrl_if: config handshake, run control and status bundle; DNCNT_AUTO_RELOAD_EN adds auto_reload
interface down_counter_timer_ctrl_if #(parameter int WIDTH = 4);
  logic cfg_valid;
  logic cfg_ready;
  logic [WIDTH-1:0] cfg_value;
  logic start;
  logic pause;
  logic abort;
  logic [WIDTH-1:0] count;
  logic busy;
  logic done;
`ifdef DNCNT_AUTO_RELOAD_EN
  logic auto_reload;
  modport master(output cfg_valid, cfg_value, start, pause, abort, auto_reload, input cfg_ready, count, busy, done);
  modport slave(input cfg_valid, cfg_value, start, pause, abort, auto_reload, output cfg_ready, count, busy, done);
`else
  modport master(output cfg_valid, cfg_value, start, pause, abort, input cfg_ready, count, busy, done);
  modport slave(input cfg_valid, cfg_value, start, pause, abort, output cfg_ready, count, busy, done);
`endif
endinterface

// File: rtl/down_counter_timer_ctrl.sv
// down_counter_timer_ctrl: programmable down-count timer sequencer; DNCNT_AUTO_RELOAD_EN enables periodic auto-reload
module down_counter_timer_ctrl #(parameter int WIDTH = 4) (
  input logic clk,
  input logic rst,
  down_counter_timer_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;
  state_t r_state, w_state_n;
  logic [WIDTH-1:0] r_count, r_reload, w_count_n;
  logic r_done, w_done_n, w_idle, w_term, w_auto;
  assign w_idle = r_state == IDLE || r_state == DONE;
  assign w_term = r_count == WIDTH'(1);
`ifdef DNCNT_AUTO_RELOAD_EN
  assign w_auto = bus.auto_reload;
`else
  assign w_auto = 1'b0;
`endif
  assign bus.cfg_ready = w_idle;
  assign bus.busy = !w_idle;
  assign bus.count = r_count;
  assign bus.done = r_done;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= IDLE;
      r_count <= '0;
      r_reload <= '0;
      r_done <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_count <= w_count_n;
      r_done <= w_done_n;
      if (bus.cfg_valid && w_idle) r_reload <= bus.cfg_value;
    end
  // start reads r_reload before any same-edge config write lands
  always_comb begin
    w_state_n = r_state;
    w_count_n = r_count;
    w_done_n = 1'b0;
    if (bus.abort) begin
      w_state_n = IDLE;
      w_count_n = '0;
    end else if (w_idle) begin
      if (bus.start) begin
        w_state_n = r_reload != '0 ? RUN : DONE;
        w_count_n = r_reload;
        w_done_n = r_reload == '0;
      end
    end else if (bus.pause) w_state_n = PAUSE;
    else if (r_state == PAUSE) w_state_n = RUN;
    else if (w_term) begin
      w_state_n = w_auto ? RUN : DONE;
      w_count_n = w_auto ? r_reload : '0;
      w_done_n = 1'b1;
    end else if (r_count != '0) w_count_n = r_count - WIDTH'(1);
  end
endmodule
